aes_128_iter_core: RTL and testbench
====================================

AES_128_ITER_CORE -- requirements
Module: aes_128_iter_core

Interface
REQ-001 Parameter RPC, default 1: AES rounds per clock; legal values 1, 2, 5; any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  core can accept a request.
REQ-006 in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 in_key  input  128  cipher key, FIPS-197 byte order (byte 0 = bits 127:120).
REQ-008 in_data  input  128  plaintext (encrypt) or ciphertext (decrypt), same byte order.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_data  output  128  result block.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-014 in_ready SHALL be high only in IDLE; accept = in_valid && in_ready.
REQ-015 On accept: in_key, in_data and in_mode registered; IDLE -> LOAD.
REQ-016 Full 11-round-key schedule SHALL derive combinationally from the registered key via the existing KeyExpansion block.
REQ-017 LOAD, one cycle: state <= data ^ rk0 (encrypt) or data ^ rk10 (decrypt); round counter <= 1; -> RUN.
REQ-018 RUN, each cycle: apply RPC consecutive rounds; counter += RPC.
REQ-019 Encrypt round r: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk r); round 10 omits MixColumns.
REQ-020 Decrypt round r: InvShiftRows, InvSubBytes, AddRoundKey(rk 10-r), InvMixColumns; round 10 omits InvMixColumns.
REQ-021 When the round-10 result is registered: -> DONE; out_valid high; out_data = state.
REQ-022 Latency SHALL be 1 + 10/RPC rising edges from the accept edge to the first edge with out_valid high: 11 edges for RPC=1, 6 for RPC=2, 3 for RPC=5.
REQ-023 DONE: out_data and out_valid held stable until out_valid && out_ready; then -> IDLE on that edge.
REQ-024 in_valid in LOAD, RUN or DONE SHALL be ignored; no queuing; input port changes while busy have no effect.
REQ-025 Round counter SHALL never exceed 10; no wrap-around.

Reset
REQ-026 rst_n low at a rising edge: FSM -> IDLE; out_valid = 0; busy = 0; out_data = 0; counter = 0; state and key registers = 0.
REQ-027 Reset in any state, including mid-RUN or DONE with out_ready low, SHALL discard the operation with no result emitted.
REQ-028 First edge with rst_n high: in_ready = 1; a request may be accepted on that edge.
REQ-029 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-030 Macro AES_DECRYPT_EN defined: inverse datapath (InvShiftRows, InvSubBytes, Inv_MixColumns) instantiated; in_mode honoured.
REQ-031 AES_DECRYPT_EN undefined: inverse datapath not instantiated; in_mode ignored; every request processed as encrypt; port list unchanged.

Verification
REQ-032 RPC=1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode 0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid 11 edges after accept.
REQ-033 AES_DECRYPT_EN defined, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 -> out_data 00112233445566778899aabbccddeeff.
REQ-034 RPC=2 and RPC=5, key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; latency 6 and 3 edges.
REQ-035 out_ready low 20 cycles in DONE, in_valid pulsed meanwhile -> out_data stable, in_ready 0, request ignored; out_ready high -> IDLE next edge.
REQ-036 rst_n low for one edge at RUN counter 5, then a new request -> no out_valid for the aborted op; new result correct at nominal latency.
REQ-037 AES_DECRYPT_EN undefined, mode 1, REQ-032 vector -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_128_iter_core_if.sv
// aes_128_iter_core_if -- request/result bundle for aes_128_iter_core.
//   in_valid/in_ready  : request handshake (in_mode, in_key, in_data travel with it)
//   out_valid/out_ready: result handshake (out_data travels with it)
//   busy               : core is in any state other than IDLE
// master = requester/consumer side, slave = core side.
interface aes_128_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_mode, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_mode, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_128_iter_core.sv
// aes_128_iter_core -- iterative AES-128 block cipher, RPC rounds per clock.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : aes_128_iter_core_if.slave (request in, result out, busy)
// Parameter RPC: rounds per clock, 1, 2 or 5 (anything else fails elaboration).
// Macro AES_DECRYPT_EN: when defined, the inverse datapath is built and
// in_mode selects decrypt; otherwise every request is encrypted.
// Latency from accept edge to first out_valid edge is 1 + 10/RPC.
module aes_128_iter_core #(
  parameter int unsigned RPC = 1
) (
  input logic              clk,
  input logic              rst_n,
  aes_128_iter_core_if.slave bus
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5)) begin : g_bad_rpc
    $error("aes_128_iter_core: RPC must be 1, 2 or 5");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // GF(2^8) arithmetic; S-boxes are computed as inverse + affine map.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and 0 -> 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i = bits 127-8i; column c holds bytes 4c..4c+3, row r = i % 4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int unsigned src;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
      o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  // Circulant column mix; row r uses coefficient k[j] on byte (r+j) % 4.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] k);
    logic [127:0] o;
    logic [7:0]   b;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        b = '0;
        for (int unsigned j = 0; j < 4; j++)
          b = b ^ gmul(s[127-8*(4*c+((r+j)%4)) -: 8], k[31-8*j -: 8]);
        o[127-8*(4*c+r) -: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = sub_shift(s);
    if (!last) t = mix(t, 32'h02030101);
    return t ^ k;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int unsigned src;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      src = 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4);
      o[127-8*i -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [127:0] t;
    t = inv_shift_sub(s) ^ k;
    if (!last) t = mix(t, 32'h0e0b0d09);
    return t;
  endfunction

  logic r_mode;
`endif

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_key, r_state, w_nxt;
  logic [3:0]   r_ctr;
  logic [127:0] w_rk [0:10];
  logic         w_last, w_accept;

  assign w_accept = (r_fsm == IDLE) && bus.in_valid;
  // Last RUN cycle is the one whose final round is round 10.
  assign w_last   = (r_ctr == 4'(11 - RPC));

  // Key schedule kept as a rolling 4-word window instead of a 44-word array.
  always_comb begin
    logic [31:0] v_w0, v_w1, v_w2, v_w3, v_t;
    logic [7:0]  v_rc;
    {v_w0, v_w1, v_w2, v_w3} = r_key;
    v_rc    = 8'h01;
    v_t     = '0;
    w_rk[0] = r_key;
    for (int unsigned k = 1; k < 11; k++) begin
      v_t  = subw({v_w3[23:0], v_w3[31:24]}) ^ {v_rc, 24'h000000};
      v_w0 = v_w0 ^ v_t;
      v_w1 = v_w1 ^ v_w0;
      v_w2 = v_w2 ^ v_w1;
      v_w3 = v_w3 ^ v_w2;
      w_rk[k] = {v_w0, v_w1, v_w2, v_w3};
      v_rc = xt(v_rc);
    end
  end

  always_comb begin
    logic [3:0] v_r;
    w_nxt = r_state;
    v_r   = r_ctr;
    for (int unsigned k = 0; k < RPC; k++) begin
      v_r = r_ctr + 4'(k);
`ifdef AES_DECRYPT_EN
      if (r_mode) w_nxt = dec_round(w_nxt, w_rk[4'd10 - v_r], v_r == 4'd10);
      else        w_nxt = enc_round(w_nxt, w_rk[v_r], v_r == 4'd10);
`else
      w_nxt = enc_round(w_nxt, w_rk[v_r], v_r == 4'd10);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) w_fsm_nxt = LOAD;
      end
      LOAD: w_fsm_nxt = RUN;
      RUN:  if (w_last) w_fsm_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  assign bus.out_data = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_state <= '0;
      r_ctr   <= '0;
    end else begin
      case (r_fsm)
        IDLE: if (w_accept) begin
          r_key   <= bus.in_key;
          r_state <= bus.in_data;
        end
        LOAD: begin
`ifdef AES_DECRYPT_EN
          r_state <= r_state ^ (r_mode ? w_rk[10] : w_rk[0]);
`else
          r_state <= r_state ^ w_rk[0];
`endif
          r_ctr   <= 4'd1;
        end
        RUN: begin
          r_state <= w_nxt;
          r_ctr   <= w_last ? 4'd10 : r_ctr + 4'(RPC);
        end
        DONE: if (bus.out_ready) r_ctr <= '0;
        default: r_ctr <= '0;
      endcase
    end
  end

`ifdef AES_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        r_mode <= 1'b0;
    else if (w_accept) r_mode <= bus.in_mode;
  end
`endif

endmodule

// File: tb/tb_aes_128_iter_core.sv
// tb_aes_128_iter_core -- directed self-checking bench; three cores (RPC 1, 2, 5)
// share one stimulus stream and are checked against FIPS-197 vectors.
module tb_aes_128_iter_core;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_mode, out_ready;
  logic [127:0] in_key, in_data;

  aes_128_iter_core_if u_if1 ();
  aes_128_iter_core_if u_if2 ();
  aes_128_iter_core_if u_if5 ();

  assign {u_if1.in_valid, u_if1.in_mode, u_if1.in_key, u_if1.in_data, u_if1.out_ready} =
         {in_valid, in_mode, in_key, in_data, out_ready};
  assign {u_if2.in_valid, u_if2.in_mode, u_if2.in_key, u_if2.in_data, u_if2.out_ready} =
         {in_valid, in_mode, in_key, in_data, out_ready};
  assign {u_if5.in_valid, u_if5.in_mode, u_if5.in_key, u_if5.in_data, u_if5.out_ready} =
         {in_valid, in_mode, in_key, in_data, out_ready};

  aes_128_iter_core #(.RPC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
  aes_128_iter_core #(.RPC(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));
  aes_128_iter_core #(.RPC(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(u_if5));

  logic         ov [3];
  logic         ir [3];
  logic         bz [3];
  logic [127:0] od [3];
  assign ov[0] = u_if1.out_valid; assign ov[1] = u_if2.out_valid; assign ov[2] = u_if5.out_valid;
  assign ir[0] = u_if1.in_ready;  assign ir[1] = u_if2.in_ready;  assign ir[2] = u_if5.in_ready;
  assign bz[0] = u_if1.busy;      assign bz[1] = u_if2.busy;      assign bz[2] = u_if5.busy;
  assign od[0] = u_if1.out_data;  assign od[1] = u_if2.out_data;  assign od[2] = u_if5.out_data;

  int           exp_lat [3] = '{11, 6, 3};
  int           n_pass = 0;
  int           n_total = 0;
  logic [127:0] res_data [3];
  int           res_lat [3];
  logic         flag [3];

  // Present one request at the next falling edge; it is accepted on the following
  // rising edge, after which the inputs are scrambled (they must be ignored).
  task automatic send(input logic mode, input logic [127:0] key, input logic [127:0] data);
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_key = key; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = ~mode; in_key = ~key; in_data = ~data;
  endtask

  // Record, per core, the first out_valid edge (counted from the accept edge).
  task automatic collect();
    logic seen [3];
    for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; res_lat[i] = -1; res_data[i] = '0; end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (!seen[i] && ov[i] === 1'b1) begin
          seen[i] = 1'b1; res_lat[i] = cyc; res_data[i] = od[i];
        end
      if (seen[0] && seen[1] && seen[2]) break;
    end
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    in_key = '1; in_data = '1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (ov[i] !== 1'b0) $display("FAIL reset_out_valid dut%0d: got %b expected 0", i, ov[i]); else n_pass++;
      n_total++; if (bz[i] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b expected 0", i, bz[i]); else n_pass++;
      n_total++; if (od[i] !== '0) $display("FAIL reset_out_data dut%0d: got %h expected 0", i, od[i]); else n_pass++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (ir[i] !== 1'b1) $display("FAIL reset_in_ready dut%0d: got %b expected 1", i, ir[i]); else n_pass++;
    end
  endtask

  task automatic test_encrypt(input string tag, input logic [127:0] k,
                              input logic [127:0] p, input logic [127:0] c);
    send(1'b0, k, p);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bz[i] !== 1'b1) $display("FAIL %s_busy dut%0d: got %b expected 1", tag, i, bz[i]); else n_pass++;
    end
    collect();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (res_data[i] !== c) $display("FAIL %s_data dut%0d: got %h expected %h", tag, i, res_data[i], c); else n_pass++;
      n_total++; if (res_lat[i] !== exp_lat[i]) $display("FAIL %s_latency dut%0d: got %0d expected %0d", tag, i, res_lat[i], exp_lat[i]); else n_pass++;
    end
    release_result();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (ir[i] !== 1'b1 || ov[i] !== 1'b0)
        $display("FAIL %s_idle dut%0d: in_ready=%b out_valid=%b expected 1/0", tag, i, ir[i], ov[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mode1(input string tag, input logic [127:0] k,
                            input logic [127:0] d, input logic [127:0] e);
    send(1'b1, k, d);
    collect();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (res_data[i] !== e) $display("FAIL %s_data dut%0d: got %h expected %h", tag, i, res_data[i], e); else n_pass++;
      n_total++; if (res_lat[i] !== exp_lat[i]) $display("FAIL %s_latency dut%0d: got %0d expected %0d", tag, i, res_lat[i], exp_lat[i]); else n_pass++;
    end
    release_result();
  endtask

  task automatic test_stall();
    send(1'b0, K2, P2);
    collect();
    for (int i = 0; i < 3; i++) flag[i] = (res_lat[i] == exp_lat[i]);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      in_valid = (j >= 5 && j < 8);
      in_key   = K1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (!(ov[i] === 1'b1 && ir[i] === 1'b0 && od[i] === C2)) flag[i] = 1'b0;
    end
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (flag[i] !== 1'b1) $display("FAIL stall_hold dut%0d: held=%b required 1 (data %h)", i, flag[i], od[i]); else n_pass++;
    end
    release_result();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (ir[i] !== 1'b1) $display("FAIL stall_release dut%0d: in_ready=%b expected 1", i, ir[i]); else n_pass++;
      flag[i] = 1'b1;
    end
    repeat (15) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (ov[i] !== 1'b0 || bz[i] !== 1'b0) flag[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++; if (flag[i] !== 1'b1) $display("FAIL stall_ignored dut%0d: quiet=%b required 1", i, flag[i]); else n_pass++;
    end
  endtask

  // Reset lands on the edge where the RPC=1 core holds counter 5 (RPC=2 would
  // finish on that same edge); neither may ever raise out_valid.
  task automatic test_abort();
    send(1'b0, K1, P1);
    flag[0] = 1'b1; flag[1] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) flag[0] = 1'b0;
      if (ov[1] !== 1'b0) flag[1] = 1'b0;
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    if (ov[0] !== 1'b0) flag[0] = 1'b0;
    if (ov[1] !== 1'b0) flag[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bz[i] !== 1'b0 || ov[i] !== 1'b0)
        $display("FAIL abort_reset dut%0d: busy=%b out_valid=%b expected 0/0", i, bz[i], ov[i]);
      else n_pass++;
    end
    // Request presented together with reset release: accepted on the first edge.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_key = K2; in_data = P2;
    @(posedge clk); #1;
    in_valid = 1'b0; in_key = K1; in_data = P1;
    collect();
    for (int i = 0; i < 2; i++) begin
      n_total++; if (flag[i] !== 1'b1) $display("FAIL abort_no_result dut%0d: quiet=%b required 1", i, flag[i]); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++; if (res_data[i] !== C2) $display("FAIL abort_new_data dut%0d: got %h expected %h", i, res_data[i], C2); else n_pass++;
      n_total++; if (res_lat[i] !== exp_lat[i]) $display("FAIL abort_new_latency dut%0d: got %0d expected %0d", i, res_lat[i], exp_lat[i]); else n_pass++;
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    test_encrypt("b2b_first", K2, P2, C2);
`ifdef AES_DECRYPT_EN
    test_mode1("b2b_second", K1, C1, P1);
`else
    test_encrypt("b2b_second", K1, P1, C1);
`endif
  endtask

  initial begin
    test_reset();
    test_encrypt("enc_fips_c1", K1, P1, C1);
    test_encrypt("enc_fips_b", K2, P2, C2);
`ifdef AES_DECRYPT_EN
    test_mode1("dec_fips_c1", K1, C1, P1);
    test_mode1("dec_fips_b", K2, C2, P2);
`else
    test_mode1("mode1_as_enc", K1, P1, C1);
`endif
    test_stall();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
